// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one fixed-latency pipelined 4x4 multiplier among
// four requesters. Results come back tagged with the requester index, in grant order.
module mult_arbiter #(
  parameter int LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] a2,
  input  logic [3:0] a3,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  input  logic [3:0] b2,
  input  logic [3:0] b3,
  output logic [3:0] gnt,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_p,
  output logic       res_valid,
  output logic [1:0] res_id,
  output logic [7:0] res_p,
  output logic [3:0] inflight
);

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } tag_t;

  logic [1:0] ptr_q, ptr_d;
  logic [3:0] mul_a_q, mul_a_d;
  logic [3:0] mul_b_q, mul_b_d;
  logic       res_valid_q;
  logic [1:0] res_id_q;
  logic [7:0] res_p_q;
  logic [3:0] inflight_q, inflight_d;
  tag_t       tag_q [LAT];

  logic       grant;
  logic [1:0] grant_id;
  logic [1:0] idx;
  logic [3:0] a_sel, b_sel;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant    = 1'b0;
    grant_id = 2'd0;
    idx      = 2'd0;
    if (en && !rst) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!grant && req[idx]) begin
          grant    = 1'b1;
          grant_id = idx;
        end
      end
    end
  end

  assign gnt = grant ? (4'b0001 << grant_id) : 4'b0000;

  always_comb begin
    a_sel = a0;
    b_sel = b0;
    case (grant_id)
      2'd1:    begin a_sel = a1; b_sel = b1; end
      2'd2:    begin a_sel = a2; b_sel = b2; end
      2'd3:    begin a_sel = a3; b_sel = b3; end
      default: begin a_sel = a0; b_sel = b0; end
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    inflight_d = inflight_q;
    if (grant) begin
      ptr_d   = grant_id + 2'd1;
      mul_a_d = a_sel;
      mul_b_d = b_sel;
    end
    // An operation stays counted until the cycle its result strobe is visible ends.
    case ({grant, res_valid_q})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours (the tag shift depends on it).
  // NOTE: the tag pipeline is a handful of flops whose valid bits must clear on
  // reset to discard in-flight work, so the whole array is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      mul_a_q     <= 4'd0;
      mul_b_q     <= 4'd0;
      res_valid_q <= 1'b0;
      res_id_q    <= 2'd0;
      res_p_q     <= 8'd0;
      inflight_q  <= 4'd0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      inflight_q <= inflight_d;
      tag_q[0]   <= grant ? tag_t'{valid: 1'b1, id: grant_id} : tag_t'{valid: 1'b0, id: 2'd0};
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      res_valid_q <= tag_q[LAT-1].valid;
      res_id_q    <= tag_q[LAT-1].id;
      if (tag_q[LAT-1].valid) begin
        res_p_q <= mul_p;
      end
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_p     = res_p_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a round-robin reference model predicts grants,
// result order, strobe timing and the in-flight count from the arbitration rules.
module tb_mult_arbiter;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] a [4];
  logic [3:0] b [4];
  logic [3:0] na [4];
  logic [3:0] nb [4];
  logic [3:0] gnt, mul_a, mul_b, inflight;
  logic [7:0] mul_p;
  logic       res_valid;
  logic [1:0] res_id;
  logic [7:0] res_p;

  typedef struct {
    int id;
    int p;
  } exp_t;

  exp_t exp_q [$];
  int   grants [$];
  int   mptr   = 0;
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;
  int   last_p = 0;
  int   peak   = 0;

  logic [7:0] mhist [LAT-1];

  mult_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
    .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]),
    .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_id(res_id), .res_p(res_p), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Environment multiplier: product of operands registered at edge e is on mul_p at edge e+LAT.
  always @(posedge clk) begin
    mhist[0] <= mul_a * mul_b;
    for (int i = 1; i < LAT - 1; i++) mhist[i] <= mhist[i-1];
  end
  assign mul_p = mhist[LAT-2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // One cycle of stimulus: drive at the falling edge, predict and check the grant.
  task automatic step(input logic r, input logic e, input logic [3:0] rq);
    int         w;
    int         prod;
    logic [3:0] eg;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a[i] = na[i];
      b[i] = nb[i];
    end
    rst = r;
    en  = e;
    req = rq;
    #1;
    w  = (r || !e) ? -1 : rr_pick(mptr, rq);
    eg = (w < 0) ? 4'b0000 : (4'b0001 << w);
    check("gnt", gnt, eg);
    while (grants.size() > 0 && grants[0] + LAT < edge_n) void'(grants.pop_front());
    if (r) begin
      exp_q.delete();
      grants.delete();
      mptr = 0;
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
    end else if (w >= 0) begin
      prod = a[w] * b[w];
      exp_q.push_back('{id: w, p: prod});
      grants.push_back(edge_n + 1);
      mptr = (w + 1) % 4;
    end
  endtask

  // Monitor: after every rising edge compare strobe, in-flight count and results.
  initial begin
    exp_t e;
    int   exp_v;
    int   cnt;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      exp_v = 0;
      cnt   = 0;
      foreach (grants[i]) begin
        if (grants[i] + LAT == edge_n) exp_v = 1;
        if (grants[i] <= edge_n && edge_n <= grants[i] + LAT) cnt++;
      end
      check("res_valid", res_valid, exp_v);
      check("inflight", inflight, cnt);
      if (inflight > peak) peak = inflight;
      if (res_valid === 1'b1) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("res_id", res_id, e.id);
          check("res_p", res_p, e.p);
          last_p = res_p;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      na[i] = 4'd0; nb[i] = 4'd0; a[i] = 4'd0; b[i] = 4'd0;
    end

    repeat (4) step(1'b1, 1'b1, 4'($urandom));

    na[0] = 4'b1010; nb[0] = 4'b1101;
    step(1'b0, 1'b1, 4'b0001);
    check("single_gnt", gnt, 4'b0001);
    repeat (6) step(1'b0, 1'b1, 4'b0000);
    check("single_product", last_p, 130);

    step(1'b1, 1'b1, 4'b0000);
    na[0] = 4'b1111; nb[0] = 4'b1011;
    na[1] = 4'b1010; nb[1] = 4'b1010;
    na[2] = 4'b0101; nb[2] = 4'b1010;
    na[3] = 4'b1110; nb[3] = 4'b0011;
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'b1111);
      check("all_order", gnt, 4'b0001 << (i % 4));
    end
    repeat (8) step(1'b0, 1'b1, 4'b0000);
    check("all_peak_inflight", peak, LAT + 1);

    step(1'b1, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0010);
    step(1'b0, 1'b1, 4'b1010);
    check("wrap_first", gnt, 4'b1000);
    step(1'b0, 1'b1, 4'b1010);
    check("wrap_second", gnt, 4'b0010);
    repeat (6) step(1'b0, 1'b1, 4'b0000);

    step(1'b0, 1'b1, 4'b0011);
    step(1'b0, 1'b1, 4'b0011);
    repeat (8) begin
      step(1'b0, 1'b0, 4'b1111);
      check("en_off_gnt", gnt, 4'b0000);
    end
    check("en_off_drained", inflight, 0);

    step(1'b0, 1'b1, 4'b0011);
    step(1'b0, 1'b1, 4'b0011);
    step(1'b1, 1'b1, 4'b0000);
    repeat (5) begin
      step(1'b0, 1'b1, 4'b0000);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_inflight", inflight, 0);
    end

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        na[i] = 4'($urandom);
        nb[i] = 4'($urandom);
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, 4'($urandom));
    end
    repeat (8) step(1'b0, 1'b1, 4'b0000);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
